pc_gen: RTL and testbench
=========================

# pc_gen

Registered program-counter generator for the MIPS datapath. It holds the word-addressed PC and computes the next PC for sequential, branch, jump, jump-and-link, jump-register, trap and exception-return flow. It presents fetch addresses to instruction memory over a valid/ready handshake. Redirects that arrive while a fetch is outstanding or stalled are buffered, so no redirect is lost.

## Interface
- `PC_W`, default 30: PC width in words (byte address bits [PC_W+1:2]); must be ≥ 26.
- `RESET_PC`, default 0: PC and EPC value after reset.
- `TRAP_PC`, default 30'h0000_0060: trap vector (word address).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `stall` in 1: pipeline stall; blocks PC advance.
- `redir_valid` in 1: one-cycle pulse; `sel` and operands are valid this cycle.
- `sel` in 3: redirect mode. SEQ=0, BR=1, JAL=2, JR=3, J=4, TRAP=5, ERET=6; 7 is treated as SEQ.
- `imm16` in 16: signed branch offset in words.
- `target26` in 26: jump target field.
- `jr_target` in PC_W: register jump target (word address).
- `fetch_ready` in 1: instruction memory accepts `pc`.
- `pc` out PC_W: current fetch address.
- `fetch_valid` out 1: `pc` is a valid fetch request.
- `fetch_squash` out 1: the fetch accepted this cycle is wrong-path.
- `pc_plus1` out PC_W: pc+1, combinational.
- `link_addr` out PC_W: pc+1, registered on a JAL redirect.
- `epc` out PC_W: exception return address.
- `pend` out 1: a redirect is buffered.

## Operation
- States:
  - BOOT: fetch_valid=0; pc=RESET_PC.
  - RUN: fetch_valid=1.
  - PEND: fetch_valid=1; redirect buffered in `pend_pc`.
- advance = fetch_valid & fetch_ready & !stall.
- Target, using pc at the redirect cycle (all sums wrap modulo 2^PC_W):
  - SEQ: pc+1.
  - BR: pc+1+sext(imm16).
  - J/JAL: {pc_plus1[PC_W-1:26], target26}.
  - JR: jr_target.
  - TRAP: TRAP_PC.
  - ERET: epc.
- Transitions:
  - BOOT → RUN unconditionally.
  - RUN, advance & !redir_valid: pc ← pc+1.
  - RUN, advance & redir_valid: pc ← target.
  - RUN, !advance & redir_valid & sel≠SEQ: pend_pc ← target; go to PEND; pc unchanged.
  - PEND, advance: pc ← pend_pc; fetch_squash=1 this cycle; go to RUN.
  - PEND, redir_valid: pend_pc ← new target (latest wins), including when advance occurs the same cycle. In that case pc ← new target, squash=1.
- TRAP captures epc ← pc in the redirect cycle, whether applied or buffered. JAL captures link_addr ← pc+1 the same way.
- A redirect with sel=SEQ does not enter PEND.

## Timing
- Reset values: pc=RESET_PC, epc=RESET_PC, link_addr=0, pend_pc=0, state=BOOT. Outputs fetch_valid, fetch_squash and pend are 0.
- First fetch_valid=1 occurs on the second rising edge after rst deasserts.
- Redirect latency: target visible on `pc` one cycle after the advance edge.
- fetch_valid, once high, stays high with `pc` stable until accepted (advance). stall never drops fetch_valid.
- fetch_squash is combinational and high only in PEND when advance=1.
- `rst` asserted mid-operation clears PEND and any buffered target immediately.

## Structure
- Package `pc_pkg` holds:
  - `sel` encodings as localparams/enum: SEL_SEQ … SEL_ERET.
  - State enum: ST_BOOT, ST_RUN, ST_PEND.
- Sub-module `pc_target`: combinational target mux over pc, sel, imm16, target26, jr_target, epc and TRAP_PC. It is instantiated once; pc_gen holds the registers and the FSM.

## Test plan
- Reset release with fetch_ready=1, no redirects → pc sequence RESET_PC, +1, +2…; fetch_valid rises on the second edge.
- pc=0x10, BR with imm16=16'hFFFC, advance → next pc=0x0D. pc=30'h3FFF_FFFF, SEQ → pc=0.
- pc=0x20, JAL with target26=0x123 → pc=0x123, link_addr=0x21. Then JR with jr_target=0x21 → pc=0x21.
- fetch_ready=0, BR pulse to 0x40 → pend=1 and pc held. A later J to 0x80 while pending → pend_pc=0x80. On ready, squash=1 and pc=0x80.
- TRAP at pc=0x55 → pc=TRAP_PC, epc=0x55. ERET → pc=0x55.
- rst pulsed while in PEND → pend=0, pc=RESET_PC, fetch_valid=0. The buffered target is never applied.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared encodings for the program-counter generator: redirect modes and FSM states.
package pc_pkg;

  localparam logic [2:0] SEL_SEQ  = 3'd0;
  localparam logic [2:0] SEL_BR   = 3'd1;
  localparam logic [2:0] SEL_JAL  = 3'd2;
  localparam logic [2:0] SEL_JR   = 3'd3;
  localparam logic [2:0] SEL_J    = 3'd4;
  localparam logic [2:0] SEL_TRAP = 3'd5;
  localparam logic [2:0] SEL_ERET = 3'd6;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } pc_state_e;

  // Encoding 7 is reserved and behaves like a sequential redirect.
  function automatic logic sel_is_seq(input logic [2:0] sel);
    return (sel == SEL_SEQ) || (sel == 3'd7);
  endfunction

endpackage

// File: rtl/pc_target.sv
// Combinational redirect-target mux: computes the next fetch address for each
// redirect mode from the PC at the redirect cycle.
module pc_target
  import pc_pkg::*;
#(
  parameter int              PC_W    = 30,
  parameter logic [PC_W-1:0] TRAP_PC = PC_W'(30'h0000_0060)
) (
  input  logic [PC_W-1:0] pc,
  input  logic [2:0]      sel,
  input  logic [15:0]     imm16,
  input  logic [25:0]     target26,
  input  logic [PC_W-1:0] jr_target,
  input  logic [PC_W-1:0] epc,
  output logic [PC_W-1:0] target
);

  logic [PC_W-1:0] pc_plus1;
  logic [PC_W-1:0] br_tgt;
  logic [PC_W-1:0] jump_tgt;

  assign pc_plus1 = pc + PC_W'(1);
  assign br_tgt   = pc_plus1 + {{(PC_W-16){imm16[15]}}, imm16};

  // Jumps keep the region bits of the delay-slot address above the 26-bit field.
  generate
    if (PC_W > 26) begin : g_jump_region
      assign jump_tgt = {pc_plus1[PC_W-1:26], target26};
    end else begin : g_jump_flat
      assign jump_tgt = PC_W'(target26);
    end
  endgenerate

  always_comb begin
    target = pc_plus1;
    case (sel)
      SEL_BR:           target = br_tgt;
      SEL_JAL, SEL_J:   target = jump_tgt;
      SEL_JR:           target = jr_target;
      SEL_TRAP:         target = TRAP_PC;
      SEL_ERET:         target = epc;
      default:          target = pc_plus1;
    endcase
  end

endmodule

// File: rtl/pc_gen.sv
// Registered program counter with valid/ready fetch handshake; redirects that
// cannot be applied immediately are buffered (latest wins) and squash the fetch.
module pc_gen
  import pc_pkg::*;
#(
  parameter int              PC_W     = 30,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [PC_W-1:0] TRAP_PC  = PC_W'(30'h0000_0060)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redir_valid,
  input  logic [2:0]      sel,
  input  logic [15:0]     imm16,
  input  logic [25:0]     target26,
  input  logic [PC_W-1:0] jr_target,
  input  logic            fetch_ready,
  output logic [PC_W-1:0] pc,
  output logic            fetch_valid,
  output logic            fetch_squash,
  output logic [PC_W-1:0] pc_plus1,
  output logic [PC_W-1:0] link_addr,
  output logic [PC_W-1:0] epc,
  output logic            pend
);

  pc_state_e       state_reg, state_next;
  logic            boot_done_reg;
  logic [PC_W-1:0] pc_reg, pc_next;
  logic [PC_W-1:0] pend_pc_reg, pend_pc_next;
  logic [PC_W-1:0] epc_reg, epc_next;
  logic [PC_W-1:0] link_reg, link_next;
  logic [PC_W-1:0] target;
  logic            advance;

  pc_target #(
    .PC_W    (PC_W),
    .TRAP_PC (TRAP_PC)
  ) u_target (
    .pc        (pc_reg),
    .sel       (sel),
    .imm16     (imm16),
    .target26  (target26),
    .jr_target (jr_target),
    .epc       (epc_reg),
    .target    (target)
  );

  assign pc        = pc_reg;
  assign pc_plus1  = pc_reg + PC_W'(1);
  assign link_addr = link_reg;
  assign epc       = epc_reg;
  assign pend      = (state_reg == ST_PEND);

  // boot_done_reg delays leaving BOOT by one edge so the first fetch request
  // appears on the second rising edge after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_BOOT;
      boot_done_reg <= 1'b0;
      pc_reg        <= RESET_PC;
      pend_pc_reg   <= '0;
      epc_reg       <= RESET_PC;
      link_reg      <= '0;
    end else begin
      state_reg     <= state_next;
      boot_done_reg <= 1'b1;
      pc_reg        <= pc_next;
      pend_pc_reg   <= pend_pc_next;
      epc_reg       <= epc_next;
      link_reg      <= link_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    pc_next      = pc_reg;
    pend_pc_next = pend_pc_reg;
    epc_next     = epc_reg;
    link_next    = link_reg;
    fetch_valid  = (state_reg != ST_BOOT);
    fetch_squash = 1'b0;
    advance      = fetch_valid & fetch_ready & ~stall;

    case (state_reg)
      ST_BOOT: begin
        if (boot_done_reg) state_next = ST_RUN;
      end
      ST_RUN: begin
        if (advance) begin
          pc_next = redir_valid ? target : pc_plus1;
        end else if (redir_valid && !sel_is_seq(sel)) begin
          pend_pc_next = target;
          state_next   = ST_PEND;
        end
      end
      ST_PEND: begin
        if (redir_valid) pend_pc_next = target;
        if (advance) begin
          fetch_squash = 1'b1;
          pc_next      = redir_valid ? target : pend_pc_reg;
          state_next   = ST_RUN;
        end
      end
      default: state_next = ST_BOOT;
    endcase

    // Side effects of TRAP/JAL are taken whether the redirect is applied or buffered.
    if (redir_valid && state_reg != ST_BOOT) begin
      if (sel == SEL_TRAP) epc_next  = pc_reg;
      if (sel == SEL_JAL)  link_next = pc_plus1;
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Testbench for pc_gen: directed vector table, reset-in-PEND sequence, then
// randomized traffic against a behavioural reference model.
module tb_pc_gen;

  localparam int          PC_W = 30;
  localparam longint      MASK = (64'd1 << PC_W) - 1;
  localparam logic [29:0] TRAP = 30'h60;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redir_valid = 1'b0;
  logic [2:0]  sel = 3'd0;
  logic [15:0] imm16 = '0;
  logic [25:0] target26 = '0;
  logic [29:0] jr_target = '0;
  logic        fetch_ready = 1'b0;
  logic [29:0] pc, pc_plus1, link_addr, epc;
  logic        fetch_valid, fetch_squash, pend;

  int n_checks = 0;
  int n_fail   = 0;

  pc_gen #(.PC_W(30), .RESET_PC(30'h0), .TRAP_PC(30'h60)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .redir_valid  (redir_valid),
    .sel          (sel),
    .imm16        (imm16),
    .target26     (target26),
    .jr_target    (jr_target),
    .fetch_ready  (fetch_ready),
    .pc           (pc),
    .fetch_valid  (fetch_valid),
    .fetch_squash (fetch_squash),
    .pc_plus1     (pc_plus1),
    .link_addr    (link_addr),
    .epc          (epc),
    .pend         (pend)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        rv;
    logic [2:0]  sel;
    logic [15:0] imm;
    logic [25:0] t26;
    logic [29:0] jr;
    logic        rdy;
    logic        sq;    // expected squash during the cycle
    logic [29:0] pc;    // expected pc after the edge
    logic        pend;
    logic [29:0] epc;
    logic [29:0] link;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic rv, input logic [2:0] s, input logic [15:0] im,
                       input logic [25:0] t, input logic [29:0] j, input logic rd);
    stall = st; redir_valid = rv; sel = s; imm16 = im; target26 = t; jr_target = j; fetch_ready = rd;
  endtask

  // Reference target: plain word arithmetic on the redirect-cycle pc.
  function automatic logic [29:0] ref_target(input logic [2:0] s, input logic [29:0] p,
      input logic [15:0] im, input logic [25:0] t, input logic [29:0] j, input logic [29:0] e);
    longint nxt = (longint'(p) + 1) & MASK;
    case (s)
      3'd1:       return 30'((nxt + longint'($signed(im))) & MASK);
      3'd2, 3'd4: return 30'((nxt - (nxt % (64'd1 << 26))) + longint'(t));
      3'd3:       return j;
      3'd5:       return TRAP;
      3'd6:       return e;
      default:    return 30'(nxt);
    endcase
  endfunction

  initial begin
    logic [29:0] m_pc, m_buf, m_epc, m_link, tg;
    logic        m_pend, adv, st, rv, rd;
    logic [2:0]  s;
    logic [15:0] im;
    logic [25:0] t;
    logic [29:0] j;

    // stall rv sel imm t26 jr rdy | sq pc pend epc link
    vecs.push_back('{0,0,3'd0,16'h0,26'h0,30'h0,1, 0,30'h1,0,30'h0,30'h0});
    vecs.push_back('{0,0,3'd0,16'h0,26'h0,30'h0,1, 0,30'h2,0,30'h0,30'h0});
    vecs.push_back('{0,1,3'd3,16'h0,26'h0,30'h10,1, 0,30'h10,0,30'h0,30'h0});
    vecs.push_back('{0,1,3'd1,16'hFFFC,26'h0,30'h0,1, 0,30'h0D,0,30'h0,30'h0});
    vecs.push_back('{0,1,3'd3,16'h0,26'h0,30'h3FFF_FFFF,1, 0,30'h3FFF_FFFF,0,30'h0,30'h0});
    vecs.push_back('{0,1,3'd0,16'h0,26'h0,30'h0,1, 0,30'h0,0,30'h0,30'h0});
    vecs.push_back('{0,1,3'd3,16'h0,26'h0,30'h20,1, 0,30'h20,0,30'h0,30'h0});
    vecs.push_back('{0,1,3'd2,16'h0,26'h123,30'h0,1, 0,30'h123,0,30'h0,30'h21});
    vecs.push_back('{0,1,3'd3,16'h0,26'h0,30'h21,1, 0,30'h21,0,30'h0,30'h21});
    vecs.push_back('{0,1,3'd1,16'h1E,26'h0,30'h0,0, 0,30'h21,1,30'h0,30'h21});
    vecs.push_back('{0,0,3'd0,16'h0,26'h0,30'h0,0, 0,30'h21,1,30'h0,30'h21});
    vecs.push_back('{0,1,3'd4,16'h0,26'h80,30'h0,0, 0,30'h21,1,30'h0,30'h21});
    vecs.push_back('{0,0,3'd0,16'h0,26'h0,30'h0,1, 1,30'h80,0,30'h0,30'h21});
    vecs.push_back('{0,1,3'd3,16'h0,26'h0,30'h55,1, 0,30'h55,0,30'h0,30'h21});
    vecs.push_back('{0,1,3'd5,16'h0,26'h0,30'h0,1, 0,30'h60,0,30'h55,30'h21});
    vecs.push_back('{0,0,3'd0,16'h0,26'h0,30'h0,1, 0,30'h61,0,30'h55,30'h21});
    vecs.push_back('{0,1,3'd6,16'h0,26'h0,30'h0,1, 0,30'h55,0,30'h55,30'h21});
    vecs.push_back('{1,0,3'd0,16'h0,26'h0,30'h0,1, 0,30'h55,0,30'h55,30'h21});
    vecs.push_back('{1,1,3'd0,16'h0,26'h0,30'h0,1, 0,30'h55,0,30'h55,30'h21});
    vecs.push_back('{1,1,3'd7,16'h0,26'h0,30'h0,1, 0,30'h55,0,30'h55,30'h21});
    vecs.push_back('{1,1,3'd1,16'h0,26'h0,30'h0,1, 0,30'h55,1,30'h55,30'h21});
    vecs.push_back('{0,1,3'd3,16'h0,26'h0,30'h99,1, 1,30'h99,0,30'h55,30'h21});
    vecs.push_back('{0,1,3'd5,16'h0,26'h0,30'h0,0, 0,30'h99,1,30'h99,30'h21});

    // Reset state and boot timing.
    drive(0, 0, 3'd0, '0, '0, '0, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_pc", 32'(pc), 32'h0);
    check("reset_fv", 32'(fetch_valid), 32'h0);
    check("reset_pend", 32'(pend), 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("boot_edge1_fv", 32'(fetch_valid), 32'h0);
    @(posedge clk); #1;
    check("boot_edge2_fv", 32'(fetch_valid), 32'h1);
    check("boot_edge2_pc", 32'(pc), 32'h0);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].stall, vecs[i].rv, vecs[i].sel, vecs[i].imm, vecs[i].t26, vecs[i].jr, vecs[i].rdy);
      #1;
      check($sformatf("v%0d_squash", i), 32'(fetch_squash), 32'(vecs[i].sq));
      check($sformatf("v%0d_fv", i), 32'(fetch_valid), 32'h1);
      @(posedge clk); #1;
      check($sformatf("v%0d_pc", i), 32'(pc), 32'(vecs[i].pc));
      check($sformatf("v%0d_pend", i), 32'(pend), 32'(vecs[i].pend));
      check($sformatf("v%0d_epc", i), 32'(epc), 32'(vecs[i].epc));
      check($sformatf("v%0d_link", i), 32'(link_addr), 32'(vecs[i].link));
    end

    // Reset while a TRAP is buffered: cleared at once and never applied.
    @(negedge clk);
    drive(0, 0, 3'd0, '0, '0, '0, 1);
    rst = 1'b1;
    #1;
    check("rstpend_pend", 32'(pend), 32'h0);
    check("rstpend_pc", 32'(pc), 32'h0);
    check("rstpend_fv", 32'(fetch_valid), 32'h0);
    check("rstpend_epc", 32'(epc), 32'h0);
    check("rstpend_link", 32'(link_addr), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("reboot_edge1_fv", 32'(fetch_valid), 32'h0);
    @(posedge clk); #1;
    check("reboot_edge2_fv", 32'(fetch_valid), 32'h1);
    @(posedge clk); #1;
    check("reboot_pc", 32'(pc), 32'h1);
    check("reboot_squash", 32'(fetch_squash), 32'h0);

    // Randomized traffic against the reference model.
    m_pc = 30'h1; m_buf = '0; m_epc = '0; m_link = '0; m_pend = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      st = ($urandom_range(0, 4) == 0);
      rv = ($urandom_range(0, 2) == 0);
      rd = ($urandom_range(0, 3) != 0);
      s  = 3'($urandom_range(0, 7));
      im = 16'($urandom);
      t  = 26'($urandom);
      j  = ($urandom_range(0, 3) == 0) ? 30'h3FFF_FFFF - 30'($urandom_range(0, 2)) : 30'($urandom);
      drive(st, rv, s, im, t, j, rd);
      adv = rd && !st;
      tg  = ref_target(s, m_pc, im, t, j, m_epc);
      #1;
      check($sformatf("r%0d_squash", n), 32'(fetch_squash), 32'(m_pend && adv));
      check($sformatf("r%0d_plus1", n), 32'(pc_plus1), 32'((longint'(m_pc) + 1) & MASK));
      if (rv && s == 3'd5) m_epc = m_pc;
      if (rv && s == 3'd2) m_link = 30'((longint'(m_pc) + 1) & MASK);
      if (m_pend) begin
        if (rv) m_buf = tg;
        if (adv) begin
          m_pc = m_buf;
          m_pend = 1'b0;
        end
      end else if (adv) begin
        m_pc = rv ? tg : 30'((longint'(m_pc) + 1) & MASK);
      end else if (rv && s != 3'd0 && s != 3'd7) begin
        m_buf = tg;
        m_pend = 1'b1;
      end
      @(posedge clk); #1;
      check($sformatf("r%0d_pc", n), 32'(pc), 32'(m_pc));
      check($sformatf("r%0d_pend", n), 32'(pend), 32'(m_pend));
      check($sformatf("r%0d_epc", n), 32'(epc), 32'(m_epc));
      check($sformatf("r%0d_link", n), 32'(link_addr), 32'(m_link));
      check($sformatf("r%0d_fv", n), 32'(fetch_valid), 32'h1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
